// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the RV32I core
// Purpose: fetch queue entry type, the NOP encoding and the default reset PC.
package rv32i_pkg;

    localparam logic [31:0] INSN_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order instruction queue for the fetch unit
// Purpose: DEPTH-entry FIFO of {pc, instr} with single-cycle flush.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data at the tail
//   push_data   entry to store
//   pop         drop the head entry
//   flush       empty the queue (overrides push and pop)
//   occupancy   number of valid entries, 0..DEPTH
//   head        oldest entry; only meaningful when occupancy != 0
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [AW:0]  occupancy,
    output fetch_entry_t head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // When full, push and pop address the same slot: the head is read
    // combinationally this cycle before the write lands.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign occupancy = count;
    assign head      = mem[rd_ptr];

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rtl/rv32i_fetch_unit.sv - RV32I instruction fetch front-end
// Purpose: owns the PC, issues word fetches, queues returned words and hands
// one {instr, pc} per cycle to decode; redirects flush queued and in-flight work.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky misaligned-redirect flag).
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr, i_imem_gnt  fetch request channel
//   i_imem_rvalid, i_imem_rdata          in-order fetch responses
//   i_redirect, i_redirect_pc            taken branch/jump target
//   o_instr_vld, i_instr_rdy             decode handshake
//   o_instr, o_instr_pc                  instruction word and its PC
//   o_misalign                           sticky misaligned-target flag
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_vld,
    input  logic        i_instr_rdy,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_misalign
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;

    logic [31:0]  pc_q;
    logic [31:0]  rsp_pc_q;     // PC of the next non-dropped response
    logic [CW-1:0] outst_q;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] occ;
    logic          started_q;   // keeps the request low until the first edge after reset
    logic          misalign_q;
    logic          credit;
    logic          grant;
    logic          push;
    logic          pop;
    logic [31:0]   target_pc;
    logic          target_misaligned;
    fetch_entry_t  head;
    fetch_entry_t  push_data;

    // The stored PC is always word aligned; the low bits only feed the flag.
    assign target_pc = i_redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_misaligned = |i_redirect_pc[1:0];
`else
    assign target_misaligned = 1'b0;
`endif

    // Credit counts in-flight requests as well as queued words so a
    // response always has a free slot waiting for it.
    assign credit      = ({1'b0, occ} + {1'b0, outst_q}) < CW1'(DEPTH);
    assign o_imem_req  = started_q && !misalign_q && credit;
    assign o_imem_addr = pc_q;
    assign grant       = o_imem_req && i_imem_gnt;

    assign o_instr_vld = (occ != '0);
    assign pop         = o_instr_vld && i_instr_rdy && !i_redirect;
    assign push        = i_imem_rvalid && (drop_q == '0) && !i_redirect;
    assign push_data   = '{pc: rsp_pc_q, instr: i_imem_rdata};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            started_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
            outst_q   <= outst_q + CW'(grant) - CW'(i_imem_rvalid);
            if (i_redirect) begin
                // Everything granted up to and including this cycle is stale.
                pc_q       <= target_pc;
                rsp_pc_q   <= target_pc;
                drop_q     <= outst_q + CW'(grant) - CW'(i_imem_rvalid);
                misalign_q <= target_misaligned;
            end else begin
                if (grant) pc_q <= pc_q + 32'd4;
                if (i_imem_rvalid) begin
                    if (drop_q != '0) drop_q <= drop_q - CW'(1);
                    else              rsp_pc_q <= rsp_pc_q + 32'd4;
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (i_redirect),
        .occupancy (occ),
        .head      (head)
    );

    assign o_instr    = o_instr_vld ? head.instr : INSN_NOP;
    assign o_instr_pc = o_instr_vld ? head.pc    : 32'h0;
    assign o_misalign = misalign_q;

endmodule
